// File: rtl/as2650_bus_arbiter.sv
// AS2650 external bus arbiter.
// Shares the 13-bit external memory/IO bus between the AS2650 core and a
// DMA/loader master. A single-cycle request becomes a timed bus cycle:
// SETUP, then one or more ACCESS cycles, then DONE. The core is held off
// through cpu_stall. The DMA side gets a one-cycle dma_ack.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | bus free; arbitrate and latch the winner's address and data
// ST_SETUP  | address stable, strobes high, pads drive if the cycle writes
// ST_ACCESS | strobe active; stays here WAIT_STATES+1 cycles
// ST_DONE   | strobes high, write data held; completes the cycle for the master

module as2650_bus_arbiter #(
  parameter int ADR_W       = 13,
  parameter int WAIT_STATES = 1
) (
  input  logic             clk,
  input  logic             rst,
  // core side
  input  logic             cpu_opreq,
  input  logic             cpu_rw,
  input  logic             cpu_m_io,
  input  logic [ADR_W-1:0] cpu_adr,
  input  logic [7:0]       cpu_dout,
  output logic [7:0]       cpu_din,
  output logic             cpu_stall,
  // DMA / loader side
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic [ADR_W-1:0] dma_adr,
  input  logic [7:0]       dma_dout,
  output logic [7:0]       dma_din,
  output logic             dma_ack,
  // pad side
  output logic [ADR_W-1:0] ext_adr,
  output logic [7:0]       ext_dout,
  input  logic [7:0]       ext_din,
  output logic             ext_oeb,
  output logic             ext_oe_n,
  output logic             ext_we_n,
  output logic             ext_m_io
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DMA = 1'b1;

  // Wait-state count reloaded on every entry to ACCESS.
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       gnt_q;
  logic       last_gnt_q;
  logic       wr_q;
  logic       wr_d;
  logic [3:0] ws_q;
  logic       ws_done;
  logic       grant_now;
  logic       grant_sel;
  logic       grant_wr;
  logic       oeb_d;
  logic       oe_n_d;
  logic       we_n_d;

  assign ws_done   = (ws_q == 4'd0);
  assign grant_now = (state_q == ST_IDLE) && (cpu_opreq || dma_req);

  // Pick a winner. When both ask at once, the one not served last wins, so
  // saturating masters alternate.
  always_comb begin
    grant_sel = GNT_CPU;
    if (cpu_opreq && dma_req) begin
      grant_sel = ~last_gnt_q;
    end else if (dma_req) begin
      grant_sel = GNT_DMA;
    end
    grant_wr = (grant_sel == GNT_DMA) ? dma_we : cpu_rw;
  end

  // Next-state sequencing of the bus cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant_now) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (ws_done) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next value of the cycle direction, so the pad controls below can be
  // registered straight from next-state terms.
  always_comb begin
    wr_d = wr_q;
    if (grant_now) begin
      wr_d = grant_wr;
    end
  end

  // Pad control decode. The pads drive from SETUP through DONE on writes.
  // The DONE cycle gives write data hold time after we_n rises.
  always_comb begin
    oeb_d  = ~(wr_d && (state_d != ST_IDLE));
    oe_n_d = ~((state_d == ST_ACCESS) && !wr_d);
    we_n_d = ~((state_d == ST_ACCESS) &&  wr_d);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Wait-state down-counter. Loaded in SETUP. ACCESS ends when it reaches zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      ws_q <= 4'd0;
    end else if (state_q == ST_SETUP) begin
      ws_q <= WS_LOAD;
    end else if ((state_q == ST_ACCESS) && !ws_done) begin
      ws_q <= ws_q - 4'd1;
    end
  end

  // Latch the winner's request when the grant is made. Later changes on the
  // request buses do not reach the pads until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q    <= GNT_CPU;
      wr_q     <= 1'b0;
      ext_adr  <= '0;
      ext_dout <= 8'h00;
      ext_m_io <= 1'b1;
    end else if (grant_now) begin
      gnt_q <= grant_sel;
      wr_q  <= grant_wr;
      if (grant_sel == GNT_DMA) begin
        ext_adr  <= dma_adr;
        ext_dout <= dma_dout;
        ext_m_io <= 1'b1;
      end else begin
        ext_adr  <= cpu_adr;
        ext_dout <= cpu_dout;
        ext_m_io <= cpu_m_io;
      end
    end
  end

  // Remember the master just served. The reset value favours the CPU on the
  // first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q <= GNT_DMA;
    end else if (state_q == ST_DONE) begin
      last_gnt_q <= gnt_q;
    end
  end

  // Registered pad strobes and the pad direction. All three are released
  // on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_oeb  <= 1'b1;
      ext_oe_n <= 1'b1;
      ext_we_n <= 1'b1;
    end else begin
      ext_oeb  <= oeb_d;
      ext_oe_n <= oe_n_d;
      ext_we_n <= we_n_d;
    end
  end

  // Capture read data at the edge that ends the last ACCESS cycle. Each
  // master's copy holds until its next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_din <= 8'h00;
      dma_din <= 8'h00;
    end else if ((state_q == ST_ACCESS) && ws_done && !wr_q) begin
      if (gnt_q == GNT_CPU) begin
        cpu_din <= ext_din;
      end else begin
        dma_din <= ext_din;
      end
    end
  end

  // Completion signalling. The core is released for exactly one cycle, in DONE.
  assign cpu_stall = cpu_opreq && !((state_q == ST_DONE) && (gnt_q == GNT_CPU));
  assign dma_ack   = (state_q == ST_DONE) && (gnt_q == GNT_DMA);

endmodule

// File: tb/tb_as2650_bus_arbiter.sv
// Directed bench for as2650_bus_arbiter.
// The main instance is built with one wait state. Two extra instances with
// zero and fifteen wait states check ACCESS length and latency.
module tb_as2650_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_opreq = 1'b0;
  logic        cpu_rw = 1'b0;
  logic        cpu_m_io = 1'b1;
  logic [12:0] cpu_adr = '0;
  logic [7:0]  cpu_dout = 8'h00;
  logic [7:0]  cpu_din;
  logic        cpu_stall;
  logic        dma_req = 1'b0;
  logic        dma_we = 1'b0;
  logic [12:0] dma_adr = '0;
  logic [7:0]  dma_dout = 8'h00;
  logic [7:0]  dma_din;
  logic        dma_ack;
  logic [12:0] ext_adr;
  logic [7:0]  ext_dout;
  logic [7:0]  ext_din = 8'h00;
  logic        ext_oeb, ext_oe_n, ext_we_n, ext_m_io;

  // zero / fifteen wait-state instances
  logic        opreq0 = 1'b0, opreq15 = 1'b0;
  logic        dma_off = 1'b0;
  logic [7:0]  din0, din15, ddin0, ddin15, dout0, dout15;
  logic        stall0, stall15, ack0, ack15;
  logic [12:0] adr0, adr15;
  logic        oeb0, oeb15, oe_n0, oe_n15, we_n0, we_n15, mio0, mio15;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  as2650_bus_arbiter #(.ADR_W(13), .WAIT_STATES(1)) dut (
    .clk(clk), .rst(rst),
    .cpu_opreq(cpu_opreq), .cpu_rw(cpu_rw), .cpu_m_io(cpu_m_io), .cpu_adr(cpu_adr),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_dout(dma_dout),
    .dma_din(dma_din), .dma_ack(dma_ack),
    .ext_adr(ext_adr), .ext_dout(ext_dout), .ext_din(ext_din), .ext_oeb(ext_oeb),
    .ext_oe_n(ext_oe_n), .ext_we_n(ext_we_n), .ext_m_io(ext_m_io)
  );

  as2650_bus_arbiter #(.ADR_W(13), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .rst(rst),
    .cpu_opreq(opreq0), .cpu_rw(cpu_rw), .cpu_m_io(cpu_m_io), .cpu_adr(cpu_adr),
    .cpu_dout(cpu_dout), .cpu_din(din0), .cpu_stall(stall0),
    .dma_req(dma_off), .dma_we(dma_off), .dma_adr(dma_adr), .dma_dout(dma_dout),
    .dma_din(ddin0), .dma_ack(ack0),
    .ext_adr(adr0), .ext_dout(dout0), .ext_din(ext_din), .ext_oeb(oeb0),
    .ext_oe_n(oe_n0), .ext_we_n(we_n0), .ext_m_io(mio0)
  );

  as2650_bus_arbiter #(.ADR_W(13), .WAIT_STATES(15)) dut_ws15 (
    .clk(clk), .rst(rst),
    .cpu_opreq(opreq15), .cpu_rw(cpu_rw), .cpu_m_io(cpu_m_io), .cpu_adr(cpu_adr),
    .cpu_dout(cpu_dout), .cpu_din(din15), .cpu_stall(stall15),
    .dma_req(dma_off), .dma_we(dma_off), .dma_adr(dma_adr), .dma_dout(dma_dout),
    .dma_din(ddin15), .dma_ack(ack15),
    .ext_adr(adr15), .ext_dout(dout15), .ext_din(ext_din), .ext_oeb(oeb15),
    .ext_oe_n(oe_n15), .ext_we_n(we_n15), .ext_m_io(mio15)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock; sample 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat0, lat15, acc0, acc15;
    lat0 = 0; lat15 = 0; acc0 = 0; acc15 = 0;

    // ---- reset state
    step(); step();
    check("rst_adr", ext_adr, 13'h0);
    check("rst_dout", ext_dout, 8'h00);
    check("rst_oeb", ext_oeb, 1'b1);
    check("rst_oe_n", ext_oe_n, 1'b1);
    check("rst_we_n", ext_we_n, 1'b1);
    check("rst_m_io", ext_m_io, 1'b1);
    check("rst_cpu_din", cpu_din, 8'h00);
    check("rst_dma_din", dma_din, 8'h00);
    check("rst_dma_ack", dma_ack, 1'b0);
    rst = 1'b0;

    // ---- 1: CPU read, one wait state
    cpu_rw = 1'b0; cpu_m_io = 1'b1; cpu_adr = 13'h0123; cpu_opreq = 1'b1; ext_din = 8'hA5;
    #1;
    check("t1_stall_c1", cpu_stall, 1'b1);
    step(); // SETUP
    check("t1_adr_setup", ext_adr, 13'h0123);
    check("t1_oe_n_setup", ext_oe_n, 1'b1);
    check("t1_stall_c2", cpu_stall, 1'b1);
    step(); // ACCESS 1
    check("t1_oe_n_acc1", ext_oe_n, 1'b0);
    check("t1_oeb_acc1", ext_oeb, 1'b1);
    check("t1_stall_c3", cpu_stall, 1'b1);
    step(); // ACCESS 2
    check("t1_oe_n_acc2", ext_oe_n, 1'b0);
    check("t1_stall_c4", cpu_stall, 1'b1);
    step(); // DONE
    check("t1_oe_n_done", ext_oe_n, 1'b1);
    check("t1_cpu_din", cpu_din, 8'hA5);
    check("t1_stall_c5", cpu_stall, 1'b0);
    cpu_opreq = 1'b0;
    step(); // IDLE
    check("t1_oe_n_idle", ext_oe_n, 1'b1);
    check("t1_cpu_din_hold", cpu_din, 8'hA5);

    // ---- 2: DMA write to the top address
    dma_we = 1'b1; dma_adr = 13'h1FFF; dma_dout = 8'h3C; dma_req = 1'b1;
    #1;
    check("t2_ack_idle", dma_ack, 1'b0);
    step(); // SETUP
    check("t2_adr", ext_adr, 13'h1FFF);
    check("t2_dout", ext_dout, 8'h3C);
    check("t2_oeb_setup", ext_oeb, 1'b0);
    check("t2_we_n_setup", ext_we_n, 1'b1);
    dma_dout = 8'h00; dma_adr = 13'h0000;
    step(); // ACCESS 1
    check("t2_we_n_acc1", ext_we_n, 1'b0);
    check("t2_oe_n_acc1", ext_oe_n, 1'b1);
    check("t2_ack_acc1", dma_ack, 1'b0);
    step(); // ACCESS 2
    check("t2_we_n_acc2", ext_we_n, 1'b0);
    check("t2_oeb_acc2", ext_oeb, 1'b0);
    step(); // DONE
    check("t2_we_n_done", ext_we_n, 1'b1);
    check("t2_oeb_done", ext_oeb, 1'b0);
    check("t2_dout_done", ext_dout, 8'h3C);
    check("t2_ack_done", dma_ack, 1'b1);
    dma_req = 1'b0;
    step(); // IDLE
    check("t2_oeb_idle", ext_oeb, 1'b1);
    check("t2_ack_idle2", dma_ack, 1'b0);

    // ---- 3: simultaneous requests after reset, then alternation
    rst = 1'b1;
    step();
    rst = 1'b0;
    cpu_rw = 1'b0; cpu_m_io = 1'b1; cpu_adr = 13'h00AA; cpu_opreq = 1'b1;
    dma_we = 1'b0; dma_adr = 13'h0155; dma_req = 1'b1; ext_din = 8'h66;
    step(); // SETUP for CPU
    check("t3_first_cpu", ext_adr, 13'h00AA);
    step(); step(); step(); // DONE
    check("t3_cpu_done_stall", cpu_stall, 1'b0);
    check("t3_cpu_din", cpu_din, 8'h66);
    check("t3_no_ack_cpu", dma_ack, 1'b0);
    ext_din = 8'h99;
    step(); // IDLE, both still pending
    check("t3_stall_idle", cpu_stall, 1'b1);
    step(); // SETUP for DMA
    check("t3_second_dma", ext_adr, 13'h0155);
    step(); step(); step(); // DONE
    check("t3_dma_ack", dma_ack, 1'b1);
    check("t3_dma_din", dma_din, 8'h99);
    check("t3_cpu_din_hold", cpu_din, 8'h66);
    check("t3_stall_dma_done", cpu_stall, 1'b1);
    step(); step(); // SETUP for CPU again
    check("t3_third_cpu", ext_adr, 13'h00AA);
    dma_req = 1'b0;
    step(); step(); step(); // DONE
    check("t3_third_stall", cpu_stall, 1'b0);
    check("t3_third_no_ack", dma_ack, 1'b0);
    cpu_opreq = 1'b0;
    step(); step();
    check("t3_idle_oe_n", ext_oe_n, 1'b1);

    // ---- 4: CPU IO write
    cpu_rw = 1'b1; cpu_m_io = 1'b0; cpu_adr = 13'h0042; cpu_dout = 8'h5A; cpu_opreq = 1'b1;
    step(); // SETUP
    check("t4_m_io_setup", ext_m_io, 1'b0);
    check("t4_dout", ext_dout, 8'h5A);
    check("t4_adr", ext_adr, 13'h0042);
    check("t4_oeb_setup", ext_oeb, 1'b0);
    cpu_dout = 8'hFF; cpu_m_io = 1'b1;
    step(); // ACCESS 1
    check("t4_m_io_acc", ext_m_io, 1'b0);
    check("t4_we_n_acc", ext_we_n, 1'b0);
    step(); // ACCESS 2
    check("t4_we_n_acc2", ext_we_n, 1'b0);
    step(); // DONE
    check("t4_m_io_done", ext_m_io, 1'b0);
    check("t4_dout_done", ext_dout, 8'h5A);
    check("t4_oeb_done", ext_oeb, 1'b0);
    check("t4_stall_done", cpu_stall, 1'b0);
    cpu_opreq = 1'b0;
    step(); // IDLE
    check("t4_oeb_idle", ext_oeb, 1'b1);

    // ---- 5: reset during ACCESS of a DMA write (CPU also waiting)
    cpu_rw = 1'b0; cpu_m_io = 1'b1; cpu_adr = 13'h0321; cpu_opreq = 1'b1;
    dma_we = 1'b1; dma_adr = 13'h0800; dma_dout = 8'h77; dma_req = 1'b1;
    step(); // SETUP, DMA wins (CPU served last)
    check("t5_dma_granted", ext_adr, 13'h0800);
    step(); // ACCESS
    check("t5_we_n_acc", ext_we_n, 1'b0);
    rst = 1'b1;
    step();
    check("t5_we_n_rst", ext_we_n, 1'b1);
    check("t5_oe_n_rst", ext_oe_n, 1'b1);
    check("t5_oeb_rst", ext_oeb, 1'b1);
    check("t5_adr_rst", ext_adr, 13'h0);
    check("t5_ack_rst", dma_ack, 1'b0);
    check("t5_stall_rst", cpu_stall, 1'b1);
    check("t5_cpu_din_rst", cpu_din, 8'h00);
    rst = 1'b0;
    step(); // SETUP, CPU wins the post-reset tie
    check("t5_cpu_after_rst", ext_adr, 13'h0321);
    check("t5_ack_setup", dma_ack, 1'b0);
    dma_req = 1'b0;
    step(); // ACCESS
    check("t5_oe_n_acc", ext_oe_n, 1'b0);
    step(); step(); // DONE
    check("t5_stall_done", cpu_stall, 1'b0);
    cpu_opreq = 1'b0;
    step();

    // ---- 6: zero and fifteen wait-state builds
    cpu_rw = 1'b0; cpu_m_io = 1'b1; cpu_adr = 13'h0010;
    opreq0 = 1'b1; opreq15 = 1'b1;
    #1;
    check("t6_stall0_c1", stall0, 1'b1);
    check("t6_stall15_c1", stall15, 1'b1);
    for (int n = 1; n <= 30; n++) begin
      step();
      if (!oe_n0) acc0++;
      if (!oe_n15) acc15++;
      if (opreq0 && !stall0) begin lat0 = n; opreq0 = 1'b0; end
      if (opreq15 && !stall15) begin lat15 = n; opreq15 = 1'b0; end
    end
    check("t6_lat_ws0", lat0, 3);
    check("t6_acc_ws0", acc0, 1);
    check("t6_lat_ws15", lat15, 18);
    check("t6_acc_ws15", acc15, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
